mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 30 +++
 rtl/mdu_alu.sv | 50 +++++
 rtl/mdu_ctrl.sv | 111 +++++++++++
 tb/tb_mdu_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU opcode and FSM state encodings, plus opcode classification helpers.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_t;

  function automatic logic is_mul(md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_alu.sv
// Combinational multiply/divide datapath; the result is staged by mdu_ctrl.
module mdu_alu
  import mdu_ctrl_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dvs;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        sgn;

  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'b0, a} * {32'b0, b};
    sgn    = (op == MD_DIV);
    // Signed divide is done on magnitudes, then signs are restored (truncation toward zero).
    a_mag  = (sgn && a[31]) ? -a : a;
    b_mag  = (sgn && b[31]) ? -b : b;
    div0   = (b == 32'd0);
    dvs    = div0 ? 32'd1 : b_mag;
    q_u    = a_mag / dvs;
    r_u    = a_mag % dvs;
    hi_n   = '0;
    lo_n   = '0;
    case (op)
      MD_MULT:  {hi_n, lo_n} = prod_s;
      MD_MULTU: {hi_n, lo_n} = prod_u;
      MD_DIV: begin
        lo_n = (a[31] ^ b[31]) ? -q_u : q_u;
        hi_n = a[31] ? -r_u : r_u;
      end
      MD_DIVU: begin
        lo_n = q_u;
        hi_n = r_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU sequencer: owns HI/LO, result staging and the busy down-counter.
//   state  | meaning
//   S_IDLE | accepting mult/div, mthi/mtlo write HI/LO directly
//   S_MUL  | multiply in flight, cnt counts remaining busy cycles
//   S_DIV  | divide in flight, commit suppressed when divisor was zero
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  E_mdop,
  input  logic [31:0] E_rs_m,
  input  logic [31:0] E_rt_m,
  input  logic        D_use_md,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] E_md_rd,
  output logic        stall_md
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  md_op_t      op;
  md_state_t   state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0] hi_s, lo_s;
  logic        skip_s;
  logic [31:0] hi_n, lo_n;
  logic        div0;
  logic        last;

  assign op   = md_op_t'(E_mdop);
  assign last = (cnt == CW'(1));

  mdu_alu u_alu (
    .op   (op),
    .a    (E_rs_m),
    .b    (E_rt_m),
    .hi_n (hi_n),
    .lo_n (lo_n),
    .div0 (div0)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_mul(op)) begin
          start     = 1'b1;
          state_nxt = S_MUL;
        end else if (is_div(op)) begin
          start     = 1'b1;
          state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        busy = 1'b1;
        if (last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      hi_s   <= '0;
      lo_s   <= '0;
      skip_s <= 1'b0;
    end else if (start) begin
      hi_s   <= hi_n;
      lo_s   <= lo_n;
      skip_s <= is_div(op) && div0;
      cnt    <= is_mul(op) ? CW'(MULT_CYC) : CW'(DIV_CYC);
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (last && !skip_s) begin
        hi <= hi_s;
        lo <= lo_s;
      end
    end else if (op == MD_MTHI) begin
      hi <= E_rs_m;
    end else if (op == MD_MTLO) begin
      lo <= E_rs_m;
    end
  end

  always_comb begin
    E_md_rd = '0;
    if (op == MD_MFHI)      E_md_rd = hi;
    else if (op == MD_MFLO) E_md_rd = lo;
  end

  assign stall_md = D_use_md && (start || busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed HI/LO results.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  E_mdop;
  logic [31:0] E_rs_m, E_rt_m;
  logic        D_use_md;
  logic        start, busy, stall_md;
  logic [31:0] hi, lo, E_md_rd;

  int errors = 0;
  int checks = 0;

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset_n(reset_n), .E_mdop(E_mdop), .E_rs_m(E_rs_m), .E_rt_m(E_rt_m),
    .D_use_md(D_use_md), .start(start), .busy(busy), .hi(hi), .lo(lo),
    .E_md_rd(E_md_rd), .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents op for one cycle, then NONE; returns start seen in the issue cycle and busy length.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic st, output int nbusy);
    E_mdop = o; E_rs_m = a; E_rt_m = b;
    #1 st = start;
    step();
    E_mdop = MD_NONE;
    nbusy = 0;
    while (busy && nbusy < 40) begin
      nbusy++;
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; E_mdop = MD_NONE; E_rs_m = '0; E_rt_m = '0; D_use_md = 1'b1;
    #2;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_md); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    D_use_md = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_mult();
    logic st; int n;
    do_op(MD_MULT, 32'hFFFFFFFE, 32'd3, st, n);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL mult_start: got %b want 1", st); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL mult_start_drop: got %b want 0", start); end
    checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
  endtask

  task automatic test_multu();
    logic st; int n;
    do_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, st, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL multu_hi: got %h want 1", hi); end
    checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
  endtask

  task automatic test_div();
    logic st; int n;
    do_op(MD_DIV, -32'sd7, 32'd2, st, n);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL div_start: got %b want 1", st); end
    checks++; if (n !== 10) begin errors++; $display("FAIL div_busy_cycles: got %0d want 10", n); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    do_op(MD_DIV, 32'd7, -32'sd2, st, n);
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negb_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL div_negb_hi: got %h want 1", hi); end
    do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, st, n);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
  endtask

  task automatic test_divu();
    logic st; int n;
    do_op(MD_DIVU, 32'd7, 32'd0, st, n);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL divu0_start: got %b want 1", st); end
    checks++; if (n !== 10) begin errors++; $display("FAIL divu0_busy_cycles: got %0d want 10", n); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divu0_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divu0_lo: got %h want 80000000", lo); end
    do_op(MD_DIVU, 32'hFFFFFFF9, 32'd16, st, n);
    checks++; if (lo !== 32'h0FFFFFFF) begin errors++; $display("FAIL divu_lo: got %h want 0fffffff", lo); end
    checks++; if (hi !== 32'h9) begin errors++; $display("FAIL divu_hi: got %h want 9", hi); end
  endtask

  task automatic test_move();
    E_mdop = MD_MTHI; E_rs_m = 32'h12345678;
    step();
    E_mdop = MD_MTLO; E_rs_m = 32'hCAFEF00D;
    #1;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL mtlo_no_start: got %b want 0", start); end
    step();
    E_mdop = MD_MFHI; E_rs_m = 32'h0;
    #1;
    checks++; if (E_md_rd !== 32'h12345678) begin errors++; $display("FAIL mfhi_rd: got %h want 12345678", E_md_rd); end
    E_mdop = MD_MFLO;
    #1;
    checks++; if (E_md_rd !== 32'hCAFEF00D) begin errors++; $display("FAIL mflo_rd: got %h want cafef00d", E_md_rd); end
    E_mdop = MD_NONE;
    #1;
    checks++; if (E_md_rd !== 32'h0) begin errors++; $display("FAIL none_rd: got %h want 0", E_md_rd); end
    step();
  endtask

  task automatic test_stall();
    int n;
    E_mdop = MD_MULT; E_rs_m = 32'd6; E_rt_m = 32'd7; D_use_md = 1'b1;
    #1;
    n = 0;
    while (stall_md && n < 40) begin
      n++;
      step();
      E_mdop = MD_NONE;
      #1;
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL stall_cycles: got %0d want 6", n); end
    E_mdop = MD_MFLO; D_use_md = 1'b0;
    #1;
    checks++; if (E_md_rd !== 32'd42) begin errors++; $display("FAIL stall_mflo_rd: got %h want 2a", E_md_rd); end
    step();
    E_mdop = MD_NONE;
  endtask

  task automatic test_back_to_back();
    int n;
    bit ign_ok;
    E_mdop = MD_MULT; E_rs_m = 32'd2; E_rt_m = 32'd3;
    step();
    E_rs_m = 32'd4; E_rt_m = 32'd5;
    n = 0; ign_ok = 1'b1;
    #1;
    while (busy && n < 40) begin
      if (start !== 1'b0) ign_ok = 1'b0;
      n++;
      step();
    end
    checks++; if (ign_ok !== 1'b1) begin errors++; $display("FAIL b2b_ignore_start: got %b want 1", ign_ok); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL b2b_first_lo: got %h want 6", lo); end
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b want 1", start); end
    step();
    E_mdop = MD_NONE;
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 5", n); end
    checks++; if (lo !== 32'd20) begin errors++; $display("FAIL b2b_second_lo: got %h want 14", lo); end
  endtask

  task automatic test_reset_mid_op();
    E_mdop = MD_DIV; E_rs_m = 32'd100; E_rt_m = 32'd7;
    step();
    E_mdop = MD_NONE;
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h want 0", lo); end
    step();
    reset_n = 1'b1;
    repeat (15) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_late_busy: got %b want 0", busy); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_mid_late_lo: got %h want 0", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_mid_late_hi: got %h want 0", hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu();
    test_move();
    test_stall();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
